// File: rtl/mul_div_unit_if.sv
// Operand/result bundle between the EXE-stage pipeline and the mul/div unit.
// The pipeline side uses the master modport and the unit uses the slave modport.
interface mul_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic             flush;
  logic [WIDTH-1:0] val1;
  logic [WIDTH-1:0] val2;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;

  modport master (
    output start, op, flush, val1, val2,
    input  hi, lo, busy, done
  );

  modport slave (
    input  start, op, flush, val1, val2,
    output hi, lo, busy, done
  );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative radix-2 multiply/divide unit with fixed, data-independent latency.
// Signed operations run on magnitudes; signs are reapplied in a single FIX cycle.
// busy/done are registered from the current state, so they trail the FSM by one
// cycle; this keeps stall timing fixed and leaves no input-to-output paths.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input logic           clk,
  input logic           rst,
  mul_div_unit_if.slave bus
);

  localparam int            CW        = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t             state_r;
  state_t             state_s;
  logic [CW-1:0]      cnt_r;
  logic [2*WIDTH-1:0] acc_r;
  logic [2*WIDTH-1:0] acc_step_s;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   b_r;
  logic [WIDTH-1:0]   v1_r;
  logic [WIDTH-1:0]   hi_r;
  logic [WIDTH-1:0]   lo_r;
  logic [WIDTH-1:0]   fix_hi_s;
  logic [WIDTH-1:0]   fix_lo_s;
  logic [WIDTH-1:0]   quo_s;
  logic [WIDTH-1:0]   rem_s;
  logic [WIDTH:0]     mul_sum_s;
  logic [WIDTH:0]     div_shift_s;
  logic [WIDTH:0]     div_diff_s;
  logic               is_div_r;
  logic               neg_res_r;
  logic               neg_rem_r;
  logic               busy_r;
  logic               done_r;
  logic               busy_s;
  logic               done_s;
  logic               accept_s;
  logic               load_s;
  logic               op_signed_s;

  // Magnitude of a two's-complement operand when the operation is signed.
  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v,
                                               input logic             sgn);
    return (sgn && v[WIDTH-1]) ? -v : v;
  endfunction

  assign op_signed_s = ~bus.op[0];
  assign bus.hi      = hi_r;
  assign bus.lo      = lo_r;
  assign bus.busy    = busy_r;
  assign bus.done    = done_r;

  // FSM state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; flush aborts only CALC/FIX, start is honoured only when idle or done.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) state_s = ST_CALC;
        else           state_s = ST_IDLE;
      end
      ST_CALC: begin
        if (bus.flush)                state_s = ST_IDLE;
        else if (cnt_r == LAST_STEP)  state_s = ST_FIX;
        else                          state_s = ST_CALC;
      end
      ST_FIX: begin
        if (bus.flush) state_s = ST_IDLE;
        else           state_s = ST_DONE;
      end
      ST_DONE: begin
        if (bus.start) state_s = ST_CALC;
        else           state_s = ST_IDLE;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Output/control decode from the current state; flush drops busy on the next cycle.
  always_comb begin
    accept_s = bus.start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
    busy_s   = ((state_r == ST_CALC) || (state_r == ST_FIX)) && !bus.flush;
    done_s   = (state_r == ST_DONE);
    load_s   = (state_r == ST_FIX) && !bus.flush;
  end

  // Registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= busy_s;
      done_r <= done_s;
    end
  end

  // One radix-2 step: shift-add for multiply, restoring shift-subtract for divide.
  always_comb begin
    mul_sum_s   = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + (acc_r[0] ? {1'b0, a_r} : {(WIDTH+1){1'b0}});
    div_shift_s = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-1]};
    div_diff_s  = div_shift_s - {1'b0, b_r};
    if (is_div_r) begin
      if (!div_diff_s[WIDTH]) begin
        acc_step_s = {div_diff_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
      end else begin
        acc_step_s = {div_shift_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_step_s = {mul_sum_s, acc_r[WIDTH-1:1]};
    end
  end

  // Sign correction and special cases applied in FIX; divide-by-zero returns the raw dividend.
  always_comb begin
    prod_s = neg_res_r ? -acc_r : acc_r;
    quo_s  = neg_res_r ? -acc_r[WIDTH-1:0] : acc_r[WIDTH-1:0];
    rem_s  = neg_rem_r ? -acc_r[2*WIDTH-1:WIDTH] : acc_r[2*WIDTH-1:WIDTH];
    if (!is_div_r) begin
      fix_hi_s = prod_s[2*WIDTH-1:WIDTH];
      fix_lo_s = prod_s[WIDTH-1:0];
    end else if (b_r == {WIDTH{1'b0}}) begin
      fix_hi_s = v1_r;
      fix_lo_s = {WIDTH{1'b1}};
    end else begin
      fix_hi_s = rem_s;
      fix_lo_s = quo_s;
    end
  end

  // Operand capture, iteration datapath and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_r     <= {(2*WIDTH){1'b0}};
      a_r       <= {WIDTH{1'b0}};
      b_r       <= {WIDTH{1'b0}};
      v1_r      <= {WIDTH{1'b0}};
      is_div_r  <= 1'b0;
      neg_res_r <= 1'b0;
      neg_rem_r <= 1'b0;
      cnt_r     <= {CW{1'b0}};
      hi_r      <= {WIDTH{1'b0}};
      lo_r      <= {WIDTH{1'b0}};
    end else begin
      if (accept_s) begin
        is_div_r  <= bus.op[1];
        a_r       <= abs_val(bus.val1, op_signed_s);
        b_r       <= abs_val(bus.val2, op_signed_s);
        v1_r      <= bus.val1;
        neg_res_r <= op_signed_s & (bus.val1[WIDTH-1] ^ bus.val2[WIDTH-1]);
        neg_rem_r <= op_signed_s & bus.val1[WIDTH-1];
        acc_r     <= {{WIDTH{1'b0}}, bus.op[1] ? abs_val(bus.val1, op_signed_s)
                                               : abs_val(bus.val2, op_signed_s)};
        cnt_r     <= {CW{1'b0}};
      end else if ((state_r == ST_CALC) && !bus.flush) begin
        acc_r <= acc_step_s;
        cnt_r <= cnt_r + CW'(1);
      end
      if (load_s) begin
        hi_r <= fix_hi_s;
        lo_r <= fix_lo_s;
      end
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: expected {hi,lo} go into a scoreboard
// queue when an operation is launched and are popped when done pulses.
module tb_mul_div_unit;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } case_t;

  logic  clk;
  logic  rst;
  int    cmp_cnt = 0;
  int    err_cnt = 0;
  exp_t  sb[$];
  case_t tbl[9];

  mul_div_unit_if #(.WIDTH(32)) bus ();

  mul_div_unit #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model built on native SystemVerilog arithmetic.
  function automatic void model(input logic [1:0] op, input logic [31:0] a,
                                input logic [31:0] b,
                                output logic [31:0] hi, output logic [31:0] lo);
    longint      p;
    logic [63:0] up;
    int          sa;
    int          sb_v;
    sa   = a;
    sb_v = b;
    hi   = 32'd0;
    lo   = 32'd0;
    case (op)
      2'b00: begin
        p = longint'(sa) * longint'(sb_v);
        up = 64'(p);
        hi = up[63:32];
        lo = up[31:0];
      end
      2'b01: begin
        up = {32'd0, a} * {32'd0, b};
        hi = up[63:32];
        lo = up[31:0];
      end
      2'b10: begin
        if (b == 32'd0) begin
          hi = a; lo = 32'hFFFF_FFFF;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          hi = 32'd0; lo = 32'h8000_0000;
        end else begin
          lo = sa / sb_v;
          hi = sa % sb_v;
        end
      end
      default: begin
        if (b == 32'd0) begin
          hi = a; lo = 32'hFFFF_FFFF;
        end else begin
          lo = a / b;
          hi = a % b;
        end
      end
    endcase
  endfunction

  // Launch an operation; called #1 after a rising edge, returns #1 after edge N.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1;
    bus.op    = op;
    bus.val1  = a;
    bus.val2  = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Wait (bounded) for done; edges counted from the edge after the start edge, 0 = timeout.
  task automatic wait_done(output int edges, output int busy_cyc);
    edges    = 0;
    busy_cyc = 0;
    for (int e = 1; e <= 60; e++) begin
      @(posedge clk);
      #1;
      if (bus.busy) busy_cyc++;
      if (bus.done) begin
        edges = e;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    cmp_cnt++;
    if ({bus.hi, bus.lo, bus.busy, bus.done} !== {32'd0, 32'd0, 1'b0, 1'b0}) begin
      err_cnt++;
      $display("FAIL reset: got hi=%h lo=%h busy=%b done=%b, want all zero",
               bus.hi, bus.lo, bus.busy, bus.done);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_arith();
    int   edges;
    int   busy_cyc;
    exp_t want;
    tbl[0] = '{2'b01, 32'd15,         32'd7,          32'h0000_0000, 32'h0000_0069};
    tbl[1] = '{2'b10, 32'd15,         32'd7,          32'h0000_0001, 32'h0000_0002};
    tbl[2] = '{2'b00, 32'hFFFF_FFFD,  32'd7,          32'hFFFF_FFFF, 32'hFFFF_FFEB};
    tbl[3] = '{2'b01, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE, 32'h0000_0001};
    tbl[4] = '{2'b10, 32'hFFFF_FFF1,  32'd7,          32'hFFFF_FFFF, 32'hFFFF_FFFE};
    tbl[5] = '{2'b10, 32'd15,         32'hFFFF_FFF9,  32'h0000_0001, 32'hFFFF_FFFE};
    tbl[6] = '{2'b11, 32'hFFFF_FFF1,  32'd7,          32'h0000_0003, 32'h2492_4922};
    tbl[7] = '{2'b11, 32'd5,          32'd0,          32'h0000_0005, 32'hFFFF_FFFF};
    tbl[8] = '{2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  32'h0000_0000, 32'h8000_0000};
    for (int i = 0; i < 9; i++) begin
      sb.push_back('{tbl[i].hi, tbl[i].lo});
      issue(tbl[i].op, tbl[i].a, tbl[i].b);
      wait_done(edges, busy_cyc);
      cmp_cnt++;
      if (edges == 0) begin
        err_cnt++;
        $display("FAIL arith[%0d] timeout: got no done in 60 edges, want done at edge 34", i);
        if (sb.size() > 0) void'(sb.pop_front());
      end else begin
        want = sb.pop_front();
        if ({bus.hi, bus.lo} !== {want.hi, want.lo}) begin
          err_cnt++;
          $display("FAIL arith[%0d] result: got hi=%h lo=%h, want hi=%h lo=%h",
                   i, bus.hi, bus.lo, want.hi, want.lo);
        end
        cmp_cnt++;
        if (edges != 34 || busy_cyc != 33) begin
          err_cnt++;
          $display("FAIL arith[%0d] latency: got done@%0d busy=%0d, want done@34 busy=33",
                   i, edges, busy_cyc);
        end
      end
    end
  endtask

  task automatic test_random();
    int          edges;
    int          busy_cyc;
    exp_t        want;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] mh;
    logic [31:0] ml;
    for (int i = 0; i < 8; i++) begin
      op = 2'(i);
      a  = $urandom;
      b  = (i % 3 == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      if (i == 6) a = 32'hFFFF_FF00;
      model(op, a, b, mh, ml);
      sb.push_back('{mh, ml});
      issue(op, a, b);
      wait_done(edges, busy_cyc);
      cmp_cnt++;
      if (edges == 0) begin
        err_cnt++;
        $display("FAIL random[%0d] timeout: got no done, want done at edge 34", i);
        if (sb.size() > 0) void'(sb.pop_front());
      end else begin
        want = sb.pop_front();
        if ({bus.hi, bus.lo} !== {want.hi, want.lo} || edges != 34) begin
          err_cnt++;
          $display("FAIL random[%0d] op=%0d a=%h b=%h: got hi=%h lo=%h @%0d, want hi=%h lo=%h @34",
                   i, op, a, b, bus.hi, bus.lo, edges, want.hi, want.lo);
        end
      end
    end
  endtask

  task automatic test_start_ignored();
    int   edges;
    int   busy_cyc;
    int   extra;
    exp_t want;
    sb.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFF6});   // MULT -2 * 5 = -10
    issue(2'b00, 32'hFFFF_FFFE, 32'd5);
    repeat (9) @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.op    = 2'b01;
    bus.val1  = 32'd1000;
    bus.val2  = 32'd1000;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done(edges, busy_cyc);
    cmp_cnt++;
    if (edges == 0) begin
      err_cnt++;
      $display("FAIL start_ignored timeout: got no done, want done at edge 34");
      if (sb.size() > 0) void'(sb.pop_front());
    end else begin
      want = sb.pop_front();
      if ({bus.hi, bus.lo} !== {want.hi, want.lo} || edges + 10 != 34) begin
        err_cnt++;
        $display("FAIL start_ignored: got hi=%h lo=%h @%0d, want hi=%h lo=%h @34",
                 bus.hi, bus.lo, edges + 10, want.hi, want.lo);
      end
    end
    extra = 0;
    for (int e = 0; e < 40; e++) begin
      @(posedge clk);
      #1;
      if (bus.busy || bus.done) extra++;
    end
    cmp_cnt++;
    if (extra != 0) begin
      err_cnt++;
      $display("FAIL start_ignored idle: got %0d busy/done cycles, want 0", extra);
    end
  endtask

  task automatic test_back_to_back();
    int   edges;
    int   busy_cyc;
    exp_t want;
    sb.push_back('{32'h0000_0000, 32'h0000_0006});   // MULTU 2*3
    issue(2'b01, 32'd2, 32'd3);
    repeat (33) @(posedge clk);
    #1;
    sb.push_back('{32'h0000_0002, 32'h0000_000E});   // DIVU 100/7
    bus.start = 1'b1;
    bus.op    = 2'b11;
    bus.val1  = 32'd100;
    bus.val2  = 32'd7;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    want = sb.pop_front();
    cmp_cnt++;
    if (bus.done !== 1'b1 || {bus.hi, bus.lo} !== {want.hi, want.lo}) begin
      err_cnt++;
      $display("FAIL b2b first: got done=%b hi=%h lo=%h, want done=1 hi=%h lo=%h",
               bus.done, bus.hi, bus.lo, want.hi, want.lo);
    end
    wait_done(edges, busy_cyc);
    cmp_cnt++;
    if (edges == 0) begin
      err_cnt++;
      $display("FAIL b2b second timeout: got no done, want done at edge 34");
      if (sb.size() > 0) void'(sb.pop_front());
    end else begin
      want = sb.pop_front();
      if ({bus.hi, bus.lo} !== {want.hi, want.lo} || edges != 34) begin
        err_cnt++;
        $display("FAIL b2b second: got hi=%h lo=%h @%0d, want hi=%h lo=%h @34",
                 bus.hi, bus.lo, edges, want.hi, want.lo);
      end
    end
  endtask

  task automatic test_flush();
    int extra;
    issue(2'b00, 32'd1234, 32'hFFFF_FFFB);
    repeat (19) @(posedge clk);
    #1;
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    cmp_cnt++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      err_cnt++;
      $display("FAIL flush status: got busy=%b done=%b, want busy=0 done=0", bus.busy, bus.done);
    end
    extra = 0;
    for (int e = 0; e < 40; e++) begin
      @(posedge clk);
      #1;
      if (bus.busy || bus.done) extra++;
    end
    cmp_cnt++;
    if (extra != 0) begin
      err_cnt++;
      $display("FAIL flush quiet: got %0d busy/done cycles, want 0", extra);
    end
    cmp_cnt++;
    if ({bus.hi, bus.lo} !== {32'h0000_0002, 32'h0000_000E}) begin
      err_cnt++;
      $display("FAIL flush hold: got hi=%h lo=%h, want hi=00000002 lo=0000000e", bus.hi, bus.lo);
    end
  endtask

  task automatic test_rst_mid();
    int   edges;
    int   busy_cyc;
    exp_t want;
    issue(2'b01, 32'd9, 32'd9);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    cmp_cnt++;
    if ({bus.hi, bus.lo, bus.busy, bus.done} !== {32'd0, 32'd0, 1'b0, 1'b0}) begin
      err_cnt++;
      $display("FAIL rst_mid state: got hi=%h lo=%h busy=%b done=%b, want all zero",
               bus.hi, bus.lo, bus.busy, bus.done);
    end
    sb.push_back('{32'hFFFF_FFFE, 32'hFFFF_FFF2});   // DIV -100/7 -> q=-14 r=-2
    issue(2'b10, 32'hFFFF_FF9C, 32'd7);
    wait_done(edges, busy_cyc);
    cmp_cnt++;
    if (edges == 0) begin
      err_cnt++;
      $display("FAIL rst_mid after timeout: got no done, want done at edge 34");
      if (sb.size() > 0) void'(sb.pop_front());
    end else begin
      want = sb.pop_front();
      if ({bus.hi, bus.lo} !== {want.hi, want.lo} || edges != 34) begin
        err_cnt++;
        $display("FAIL rst_mid after: got hi=%h lo=%h @%0d, want hi=%h lo=%h @34",
                 bus.hi, bus.lo, edges, want.hi, want.lo);
      end
    end
  endtask

  initial begin
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.flush = 1'b0;
    bus.val1  = 32'd0;
    bus.val2  = 32'd0;
    test_reset();
    test_arith();
    test_random();
    test_start_ignored();
    test_back_to_back();
    test_flush();
    test_rst_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
